// File: rtl/mips_mem_pkg.sv
// Shared types and default sizing for the MIPS memory responder.
package mips_mem_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_WAIT_CYCLES = 2;
  localparam int CNT_W               = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mips_mem_array.sv
// Single-port word RAM: synchronous write, combinational read.
module mips_mem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mips_mem_responder.sv
// Wait-stated memory responder for a MIPS core (IDLE -> BUSY -> DONE).
// Optional macro MIPS_MEM_RESPONDER_ALIGN_CHECK_EN rejects misaligned requests.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        init,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [AW-1:0]    idx_reg;
  logic [31:0]      wdata_reg;
  logic             is_write_reg;
  logic [31:0]      mem_rdata;
  logic             mem_we;
  logic             one_req;
  logic             reject;
  logic             unused_addr_bits;

  assign one_req = mem_read ^ mem_write;

`ifdef MIPS_MEM_RESPONDER_ALIGN_CHECK_EN
  assign reject = (mem_read & mem_write) |
                  ((mem_read | mem_write) & (addr[1:0] != 2'b00));
`else
  assign reject = mem_read & mem_write;
`endif

  // Upper address bits wrap; byte-lane bits only matter with alignment checks.
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  // Write lands on the edge that leaves DONE; init suppresses it.
  assign mem_we = (state_reg == DONE) & is_write_reg & ~init;

  mips_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (idx_reg),
    .wdata(wdata_reg),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (init) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (reject) begin
            err <= 1'b1;
          end else if (one_req) begin
            idx_reg      <= addr[AW+1:2];
            wdata_reg    <= wdata;
            is_write_reg <= mem_write;
            cnt_reg      <= CNT_W'(WAIT_CYCLES);
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg == '0) begin
            state_reg <= DONE;
            ready     <= 1'b1;
            if (!is_write_reg) begin
              rdata <= mem_rdata;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
